sprite_compositor: RTL and testbench

//  Downstream of the per-sprite drawing engines. Merges N sprite pixel streams
//  and a background pixel into one display colour by fixed priority and transparency.

---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_palette.sv | 49 ++++
 rtl/sprite_compositor.sv | 117 +++++++++++
 tb/tb_sprite_compositor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, default palette contents and the collision pair indexing rule.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int DEFAULT_PAL_DEPTH = 16;

  // Colours loaded into the palette whenever the compositor is reset.
  localparam logic [11:0] DEFAULT_PALETTE [DEFAULT_PAL_DEPTH] = '{
    12'h000, 12'hFFF, 12'h833, 12'h7CC, 12'h849, 12'h5A4, 12'h339, 12'hBD7,
    12'h852, 12'h540, 12'hC66, 12'h444, 12'h777, 12'hAF9, 12'h76C, 12'hAAA
  };

  // Reset colour for a palette entry; entries beyond the default table are black.
  function automatic rgb_t default_colour(input int idx);
    if (idx >= 0 && idx < DEFAULT_PAL_DEPTH) begin
      return rgb_t'(DEFAULT_PALETTE[idx]);
    end
    return '0;
  endfunction

  // Bit position of sprite pair (i,j), i<j, in an n-sprite collision vector.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sprite_palette.sv
// Writable colour palette: one write port, one registered read port.
// A write and a read of the same entry on the same edge return the old colour.
module sprite_palette
  import sprite_pkg::*;
#(
  parameter int COLR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [COLR_BITS-1:0] waddr_i,
  input  logic [11:0]          wdata_i,
  input  logic                 rd_en_i,
  input  logic [COLR_BITS-1:0] raddr_i,
  output logic [11:0]          rdata_o
);

  localparam int DEPTH = 2 ** COLR_BITS;

  rgb_t mem_q [DEPTH];
  rgb_t rdata_q;

  // Palette storage: reload defaults on reset, accept one write per clock.
  // NOTE: the array is reset explicitly because the palette must come back to
  // known colours after every reset, so it is built from flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= default_colour(k);
      end
    end else if (we_i) begin
      // NOTE: non-blocking writes mean a lookup on this same edge still sees
      // the previous colour, which is exactly the read-old behaviour wanted.
      mem_q[waddr_i] <= rgb_t'(wdata_i);
    end
  end

  // Registered lookup; blanked outside active video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_en_i ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: fixed-priority sprite/background merge, palette lookup
// (2-clock pipeline) and per-frame pairwise sprite collision reporting.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter  int N_SPR     = 4,
  parameter  int COLR_BITS = 4,
  parameter  int TRANSP    = 0,
  localparam int N_PAIR    = N_SPR * (N_SPR - 1) / 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame,
  input  logic                       de,
  input  logic [N_SPR-1:0]           spr_drawing,
  input  logic [N_SPR*COLR_BITS-1:0] spr_pix,
  input  logic [COLR_BITS-1:0]       bg_pix,
  input  logic                       pal_we,
  input  logic [COLR_BITS-1:0]       pal_addr,
  input  logic [11:0]                pal_data,
  output logic [11:0]                rgb,
  output logic                       de_out,
  output logic [N_PAIR-1:0]          coll,
  output logic                       coll_valid
);

  logic [N_SPR-1:0]     opaque;
  logic [COLR_BITS-1:0] sel_d, sel_q;
  logic                 de_d1_q, de_d2_q;
  logic [N_PAIR-1:0]    hit;
  logic [N_PAIR-1:0]    acc_d, acc_q;
  logic [N_PAIR-1:0]    coll_d, coll_q;
  logic                 coll_valid_q;

  // A sprite covers the pixel when it is drawing a non-transparent index.
  always_comb begin
    opaque = '0;
    for (int i = 0; i < N_SPR; i++) begin
      opaque[i] = spr_drawing[i] &&
                  (spr_pix[i*COLR_BITS +: COLR_BITS] != COLR_BITS'(TRANSP));
    end
  end

  // Priority mux: lowest-numbered opaque sprite wins, else background in video.
  // NOTE: the default is assigned before the loop so every path drives sel_d
  // and no latch is inferred.
  always_comb begin
    sel_d = de ? bg_pix : '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        sel_d = spr_pix[i*COLR_BITS +: COLR_BITS];
      end
    end
  end

  // Pairwise overlap of opaque sprites during active video; hidden ones count.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPR; i++) begin
      for (int j = i + 1; j < N_SPR; j++) begin
        hit[pair_idx(i, j, N_SPR)] = de && opaque[i] && opaque[j];
      end
    end
  end

  // Frame pulse publishes the finished frame and restarts accumulation with
  // this cycle's hits, which belong to the new frame.
  always_comb begin
    acc_d  = frame ? hit : (acc_q | hit);
    coll_d = frame ? acc_q : coll_q;
  end

  // Pipeline stage 1 plus the display-enable delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      de_d1_q <= 1'b0;
      de_d2_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      de_d1_q <= de;
      de_d2_q <= de_d1_q;
    end
  end

  // Collision accumulator and published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      coll_q       <= '0;
      coll_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      coll_q       <= coll_d;
      coll_valid_q <= frame;
    end
  end

  // Stage 2: palette lookup, registered inside the palette.
  sprite_palette #(
    .COLR_BITS (COLR_BITS)
  ) u_palette (
    .clk     (clk),
    .rst     (rst),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_data),
    .rd_en_i (de_d1_q),
    .raddr_i (sel_q),
    .rdata_o (rgb)
  );

  assign de_out     = de_d2_q;
  assign coll       = coll_q;
  assign coll_valid = coll_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench: each issued pixel pushes its expected colour and each
// frame pulse pushes its expected collision word; a monitor pops and compares.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int NS = 4;
  localparam int CB = 4;
  localparam int NP = NS * (NS - 1) / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame, de, pal_we;
  logic [NS-1:0]   spr_drawing;
  logic [NS*CB-1:0] spr_pix;
  logic [CB-1:0]   bg_pix, pal_addr;
  logic [11:0]     pal_data;
  logic [11:0]     rgb;
  logic            de_out, coll_valid;
  logic [NP-1:0]   coll;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [11:0]   m_pal [16];
  logic [NP-1:0] m_acc;
  logic [NP-1:0] m_coll_hold;
  logic [12:0]   exp_q [$];
  logic [NP-1:0] coll_q [$];

  sprite_compositor #(.N_SPR(NS), .COLR_BITS(CB), .TRANSP(0)) dut (
    .clk(clk), .rst(rst), .frame(frame), .de(de),
    .spr_drawing(spr_drawing), .spr_pix(spr_pix), .bg_pix(bg_pix),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb), .de_out(de_out), .coll(coll), .coll_valid(coll_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_pal[k] = DEFAULT_PALETTE[k];
    m_acc = '0;
    m_coll_hold = '0;
    exp_q.delete();
    coll_q.delete();
  endtask

  // Drive one pixel's inputs (already at a negedge) and record expectations.
  task automatic issue(input logic f, input logic d, input logic [NS-1:0] drw,
                       input logic [NS*CB-1:0] pix, input logic [CB-1:0] bg,
                       input logic we, input logic [CB-1:0] wa, input logic [11:0] wd);
    logic [CB-1:0] s [NS];
    bit            op [NS];
    int            winner;
    logic [CB-1:0] idx;
    logic [NP-1:0] h;
    int            k;
    frame = f; de = d; spr_drawing = drw; spr_pix = pix; bg_pix = bg;
    pal_we = we; pal_addr = wa; pal_data = wd;
    winner = -1;
    for (int i = 0; i < NS; i++) begin
      s[i]  = pix[i*CB +: CB];
      op[i] = drw[i] && (s[i] != 0);
      if (op[i] && winner < 0) winner = i;
    end
    idx = (winner >= 0) ? s[winner] : bg;
    // A write in this cycle is visible to this pixel's lookup one edge later.
    if (we) m_pal[wa] = wd;
    exp_q.push_back({d, d ? m_pal[idx] : 12'h000});
    h = '0;
    k = 0;
    for (int i = 0; i < NS; i++) begin
      for (int j = i + 1; j < NS; j++) begin
        h[k] = d && op[i] && op[j];
        k++;
      end
    end
    if (f) begin
      coll_q.push_back(m_acc);
      m_acc = h;
    end else begin
      m_acc = m_acc | h;
    end
  endtask

  task automatic cyc(input logic f, input logic d, input logic [NS-1:0] drw,
                     input logic [NS*CB-1:0] pix, input logic [CB-1:0] bg);
    @(negedge clk);
    issue(f, d, drw, pix, bg, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    frame = 0; de = 0; spr_drawing = '0; spr_pix = '0; bg_pix = '0;
    pal_we = 0; pal_addr = '0; pal_data = '0;
    #1;
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_de_out", 32'(de_out), 32'h0);
    check("rst_coll", 32'(coll), 32'h0);
    check("rst_coll_valid", 32'(coll_valid), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: outputs after edge e belong to the pixel issued before edge e-1.
  initial begin
    logic [12:0] item;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() >= 2) begin
          item = exp_q.pop_front();
          check("rgb", 32'(rgb), 32'(item[11:0]));
          check("de_out", 32'(de_out), 32'(item[12]));
        end
        check("coll_valid", 32'(coll_valid), 32'(coll_q.size() > 0));
        if (coll_q.size() > 0) m_coll_hold = coll_q.pop_front();
        check("coll", 32'(coll), 32'(m_coll_hold));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS*CB-1:0] p;
    rst = 1'b1;
    frame = 0; de = 0; spr_drawing = '0; spr_pix = '0; bg_pix = '0;
    pal_we = 0; pal_addr = '0; pal_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("init_rgb", 32'(rgb), 32'h0);
    check("init_coll_valid", 32'(coll_valid), 32'h0);
    rst = 1'b0;
    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);

    // Priority and transparency: spr0 transparent, spr1=5 beats spr2=9.
    cyc(1'b0, 1'b1, 4'b0111, 16'h0950, 4'd3);
    cyc(1'b0, 1'b1, 4'b0000, 16'h0950, 4'd3);
    cyc(1'b0, 1'b0, 4'b0111, 16'h0950, 4'd3);
    idle(2);

    // Collision (1,3) in active video, then the same overlap outside it.
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 4'b1010, 16'h7060, 4'd2);
    idle(3);
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 4'b1010, 16'h7060, 4'd2);
    idle(2);
    cyc(1'b1, 1'b0, '0, '0, '0);
    idle(2);

    // Overlap (0,1) coinciding with frame belongs to the new frame.
    cyc(1'b1, 1'b1, 4'b0011, 16'h0021, 4'd4);
    idle(3);
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0, '0);
    idle(2);

    // Palette write while index 5 streams.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(1'b0, 1'b1, 4'b0001, 16'h0005, 4'd1, (i == 3), 4'd5, 12'hF0F);
    end
    idle(2);

    // Reset mid-stream restores the default palette and drops the accumulator.
    cyc(1'b0, 1'b1, 4'b0011, 16'h0055, 4'd1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'b0001, 16'h0005, 4'd1);
    cyc(1'b0, 1'b1, 4'b1100, 16'h3300, 4'd1);
    cyc(1'b1, 1'b0, '0, '0, '0);
    idle(2);

    // Randomised stream.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NS; i++) begin
        p[i*CB +: CB] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      issue(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
            4'($urandom_range(0, 15)), p, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            12'($urandom_range(0, 4095)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
